// File: rtl/dot_led_fetch_sched.sv
// dot_led_fetch_sched: row-fetch scheduler for the dot-LED VDMA.
// Fetches one LED-matrix row per handshake from a double-buffered frame buffer,
// issuing one burst command at a time and swapping buffers on frame boundaries.
// Optional feature: define DOT_LED_SCHED_UNDERRUN_CNT_EN to build the saturating
// underrun counter; otherwise underrun_cnt is tied to zero.

module dot_led_fetch_sched #(
   parameter int  ADDR_WIDTH     = 32,
   parameter int  ROWS           = 16,
   parameter int  BURSTS_PER_ROW = 2,
   parameter int  BURST_BYTES    = 64,
   localparam int RW             = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] fb_base0,
   input  logic [ADDR_WIDTH-1:0] fb_base1,
   input  logic                  swap_req,
   output logic                  cur_fb,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  done_valid,
   input  logic                  done_err,
   output logic                  row_ready,
   input  logic                  row_req,
   output logic [RW-1:0]         row_idx,
   output logic                  frame_start,
   output logic                  busy,
   output logic                  error,
   output logic [15:0]           underrun_cnt
);

   localparam int                    BW         = (BURSTS_PER_ROW > 1) ? $clog2(BURSTS_PER_ROW) : 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BURSTS_PER_ROW * BURST_BYTES);
   localparam logic [ADDR_WIDTH-1:0] BBYTES     = ADDR_WIDTH'(BURST_BYTES);
   localparam logic [RW-1:0]         LAST_ROW   = RW'(ROWS - 1);
   localparam logic [BW-1:0]         LAST_BURST = BW'(BURSTS_PER_ROW - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_READY, S_ERROR} state_t;

   function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [RW-1:0]         row,
                                                     input logic [BW-1:0]         burst);
      return base + ADDR_WIDTH'(row) * STRIDE + ADDR_WIDTH'(burst) * BBYTES;
   endfunction

   state_t                r_state;
   logic                  r_cur_fb;
   logic                  r_swap_pending;
   logic [RW-1:0]         r_row_idx;
   logic [BW-1:0]         r_burst;
   logic                  r_cmd_valid;
   logic [ADDR_WIDTH-1:0] r_cmd_addr;
   logic                  r_row_ready;
   logic                  r_frame_start;
   logic                  r_busy;
   logic                  r_error;

   logic                  w_swap_now;
   logic                  w_fb_next;
   logic [BW-1:0]         w_burst_inc;
   logic [RW-1:0]         w_row_inc;
   logic [ADDR_WIDTH-1:0] w_base_cur;
   logic [ADDR_WIDTH-1:0] w_addr_frame;
   logic [ADDR_WIDTH-1:0] w_addr_burst;
   logic [ADDR_WIDTH-1:0] w_addr_row;

   // A swap request arriving on the application edge is folded into that application.
   assign w_swap_now   = r_swap_pending | swap_req;
   assign w_fb_next    = r_cur_fb ^ w_swap_now;
   assign w_burst_inc  = r_burst + 1'b1;
   assign w_row_inc    = r_row_idx + 1'b1;
   assign w_base_cur   = r_cur_fb ? fb_base1 : fb_base0;
   assign w_addr_frame = f_addr(w_fb_next ? fb_base1 : fb_base0, '0, '0);
   assign w_addr_burst = f_addr(w_base_cur, r_row_idx, w_burst_inc);
   assign w_addr_row   = f_addr(w_base_cur, w_row_inc, '0);

   // Scheduler FSM with all outputs registered alongside the state.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state        <= S_IDLE;
         r_cur_fb       <= 1'b0;
         r_swap_pending <= 1'b0;
         r_row_idx      <= '0;
         r_burst        <= '0;
         r_cmd_valid    <= 1'b0;
         r_cmd_addr     <= '0;
         r_row_ready    <= 1'b0;
         r_frame_start  <= 1'b0;
         r_busy         <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (swap_req) r_swap_pending <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_cur_fb       <= w_fb_next;
                  r_swap_pending <= 1'b0;
                  r_row_idx      <= '0;
                  r_burst        <= '0;
                  r_cmd_valid    <= 1'b1;
                  r_cmd_addr     <= w_addr_frame;
                  r_frame_start  <= 1'b1;
                  r_busy         <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (done_valid) begin
                  if (done_err) begin
                     r_error <= 1'b1;
                     r_state <= S_ERROR;
                  end else if (!enable) begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else if (r_burst == LAST_BURST) begin
                     r_row_ready <= 1'b1;
                     r_state     <= S_READY;
                  end else begin
                     r_burst     <= w_burst_inc;
                     r_cmd_valid <= 1'b1;
                     r_cmd_addr  <= w_addr_burst;
                     r_state     <= S_ISSUE;
                  end
               end
            end
            S_READY: begin
               if (!enable) begin
                  r_row_ready <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (row_req) begin
                  r_row_ready <= 1'b0;
                  r_burst     <= '0;
                  r_cmd_valid <= 1'b1;
                  r_state     <= S_ISSUE;
                  if (r_row_idx == LAST_ROW) begin
                     r_row_idx      <= '0;
                     r_cur_fb       <= w_fb_next;
                     r_swap_pending <= 1'b0;
                     r_frame_start  <= 1'b1;
                     r_cmd_addr     <= w_addr_frame;
                  end else begin
                     r_row_idx  <= w_row_inc;
                     r_cmd_addr <= w_addr_row;
                  end
               end
            end
            S_ERROR: begin
               if (!enable) begin
                  r_error <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cur_fb      = r_cur_fb;
   assign cmd_valid   = r_cmd_valid;
   assign cmd_addr    = r_cmd_addr;
   assign row_ready   = r_row_ready;
   assign row_idx     = r_row_idx;
   assign frame_start = r_frame_start;
   assign busy        = r_busy;
   assign error       = r_error;

`ifdef DOT_LED_SCHED_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   // Count row requests arriving while no row is held; saturates, cleared only by reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_underrun_cnt <= '0;
      end else if (row_req && !r_row_ready && (r_underrun_cnt != 16'hFFFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign underrun_cnt = r_underrun_cnt;
`else
   assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dot_led_fetch_sched.sv
// Bench for dot_led_fetch_sched: randomized engine/driver stimulus, a frame-level
// reference model feeding an expected-command queue, and a monitor that checks
// every presented command.

module tb_dot_led_fetch_sched;

   localparam int AW   = 32;
   localparam int ROWS = 16;
   localparam int BPR  = 2;
   localparam int BB   = 64;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        enable, swap_req, cmd_ready, done_valid, done_err, row_req;
   logic [31:0] fb_base0, fb_base1, cmd_addr;
   logic        cur_fb, cmd_valid, row_ready, frame_start, busy, error;
   logic [3:0]  row_idx;
   logic [15:0] underrun_cnt;

   always #5 ACLK = ~ACLK;

   dot_led_fetch_sched #(
      .ADDR_WIDTH(AW), .ROWS(ROWS), .BURSTS_PER_ROW(BPR), .BURST_BYTES(BB)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
      .fb_base0(fb_base0), .fb_base1(fb_base1), .swap_req(swap_req), .cur_fb(cur_fb),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .done_valid(done_valid), .done_err(done_err),
      .row_ready(row_ready), .row_req(row_req), .row_idx(row_idx),
      .frame_start(frame_start), .busy(busy), .error(error), .underrun_cnt(underrun_cnt)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  row;
      logic        fb;
      logic        fs;
   } cmd_t;

   cmd_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   // reference model: frame position and expected visible flags (current / after next edge)
   bit          m_fb, m_pend;
   int          m_row, m_burst;
   bit          exp_rdy, rdy_nx, exp_busy, busy_nx, exp_err, err_nx;
   logic [15:0] exp_under, under_nx;

   // burst engine / driver state and knobs
   bit eng_out;
   int eng_dly, hold, min_dly;
   bit s_hs, s_valid;
   bit en_knob, rr_on, ur_on, sw_on, spur_on, base_on, tog_on, inject, did7;
   bit mon_en;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_addr(input bit fb, input int row, input int burst);
      logic [31:0] base;
      base = fb ? fb_base1 : fb_base0;
      return base + 32'(row * BPR * BB) + 32'(burst * BB);
   endfunction

   task automatic push(input bit fs);
      cmd_t c;
      c.addr = ref_addr(m_fb, m_row, m_burst);
      c.row  = 4'(m_row);
      c.fb   = m_fb;
      c.fs   = fs;
      exp_q.push_back(c);
   endtask

   task automatic start_frame();
      m_fb    = m_fb ^ m_pend;
      m_pend  = 1'b0;
      m_row   = 0;
      m_burst = 0;
      push(1'b1);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_fb = 0; m_pend = 0; m_row = 0; m_burst = 0;
      exp_rdy = 0; rdy_nx = 0; exp_busy = 0; busy_nx = 0; exp_err = 0; err_nx = 0;
      exp_under = '0; under_nx = '0;
      eng_out = 0; eng_dly = 0; s_hs = 0; s_valid = 0;
   endtask

   // Drive inputs for the next edge and advance the model accordingly.
   task automatic drive();
      row_req = 0; swap_req = 0; done_valid = 0; done_err = 0;
      if (tog_on && $urandom_range(0, 299) == 0) en_knob = !en_knob;
      enable = en_knob;
      if (base_on && $urandom_range(0, 149) == 0) begin
         if ($urandom_range(0, 1) == 1) fb_base0 = $urandom;
         else                           fb_base1 = $urandom;
      end
      if (s_hs) begin
         eng_out = 1;
         eng_dly = $urandom_range(min_dly, 3);
         hold    = $urandom_range(0, 5);
      end
      cmd_ready = (hold == 0);
      if (sw_on && !did7 && exp_busy && m_row == 7) begin
         swap_req = 1; m_pend = 1; did7 = 1;
      end else if (sw_on && $urandom_range(0, 199) == 0) begin
         swap_req = 1; m_pend = 1;
      end
      if (!exp_busy && enable) begin
         busy_nx = 1;
         start_frame();
      end
      if (exp_rdy && !enable) begin rdy_nx = 0; busy_nx = 0; end
      if (exp_err && !enable) begin err_nx = 0; busy_nx = 0; end
      if (eng_out) begin
         if (eng_dly > 0) eng_dly--;
         else begin
            done_valid = 1;
            eng_out    = 0;
            if (inject && m_row == 2 && m_burst == 1) begin
               done_err = 1; inject = 0; err_nx = 1;
            end else if (!enable) begin
               busy_nx = 0;
            end else if (m_burst == BPR - 1) begin
               rdy_nx = 1;
            end else begin
               m_burst++;
               push(1'b0);
            end
         end
      end else if (spur_on && $urandom_range(0, 9) == 0) begin
         done_valid = 1;
         done_err   = 1'($urandom_range(0, 1));
      end
      if (exp_rdy && enable && rr_on && $urandom_range(0, 1) == 0) begin
         row_req = 1;
         rdy_nx  = 0;
         if (m_row == ROWS - 1) start_frame();
         else begin
            m_row++;
            m_burst = 0;
            push(1'b0);
         end
      end else if (!exp_rdy && ur_on && $urandom_range(0, 29) == 0) begin
         row_req = 1;
`ifdef DOT_LED_SCHED_UNDERRUN_CNT_EN
         if (under_nx != 16'hFFFF) under_nx = under_nx + 16'd1;
`endif
      end
   endtask

   task automatic step();
      @(negedge ACLK);
      chk("row_ready", 32'(row_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("error", 32'(error), 32'(exp_err));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_under));
      if (exp_err) chk("cmd_valid_in_error", 32'(cmd_valid), 32'd0);
      s_hs    = cmd_valid && cmd_ready;
      s_valid = cmd_valid;
      if (cmd_valid && !cmd_ready && hold > 0) hold--;
      @(posedge ACLK);
      exp_rdy = rdy_nx; exp_busy = busy_nx; exp_err = err_nx; exp_under = under_nx;
      #1;
      drive();
   endtask

   task automatic drain();
      int n;
      en_knob = 0; tog_on = 0; rr_on = 0; ur_on = 0; sw_on = 0; base_on = 0; spur_on = 0;
      n = 0;
      while ((exp_busy || busy_nx || eng_out || exp_q.size() != 0) && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=busy_after_%0d_cycles required=idle", n);
      end
      repeat (5) step();
   endtask

   // Monitor: pops the expected command whenever the DUT presents a new one.
   initial begin
      cmd_t cur;
      bit   prev_valid;
      bit   fs_exp;
      prev_valid = 0;
      cur.addr = '0; cur.row = '0; cur.fb = 0; cur.fs = 0;
      forever begin
         @(negedge ACLK);
         if (mon_en) begin
            fs_exp = 0;
            if (cmd_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_cmd actual addr=%h required=no_command", cmd_addr);
               end else begin
                  cur = exp_q.pop_front();
                  chk("cmd_addr", cmd_addr, cur.addr);
                  chk("row_idx", 32'(row_idx), 32'(cur.row));
                  chk("cur_fb", 32'(cur_fb), 32'(cur.fb));
                  chk("single_outstanding", 32'(eng_out), 32'd0);
                  fs_exp = cur.fs;
               end
            end else if (cmd_valid) begin
               chk("cmd_addr_hold", cmd_addr, cur.addr);
            end
            chk("frame_start", 32'(frame_start), 32'(fs_exp));
         end
         prev_valid = cmd_valid;
      end
   end

   initial begin
      int n;
      ARESETN = 0; enable = 0; swap_req = 0; cmd_ready = 0; done_valid = 0; done_err = 0; row_req = 0;
      fb_base0 = 32'h1000_0000; fb_base1 = 32'h2000_0000;
      model_reset();
      hold = 5; min_dly = 0; mon_en = 0;
      en_knob = 0; rr_on = 0; ur_on = 0; sw_on = 0; spur_on = 0; base_on = 0; tog_on = 0;
      inject = 0; did7 = 0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_row_idx", 32'(row_idx), 32'd0);
      chk("reset_cur_fb", 32'(cur_fb), 32'd0);
      ARESETN = 1;
      mon_en  = 1;

      // random operation with swaps, backpressure, underruns, spurious dones
      en_knob = 1; rr_on = 1; ur_on = 1; sw_on = 1; spur_on = 1;
      repeat (400) step();
      base_on = 1; tog_on = 1;
      repeat (3000) step();
      drain();

      // burst error on row 2 burst 1, recovery by disable/enable
      en_knob = 1; rr_on = 1; inject = 1;
      n = 0;
      while (!exp_err && n < 3000) begin step(); n++; end
      if (!exp_err) begin
         checks++; failures++;
         $display("FAIL error_inject_timeout actual=no_error required=error");
      end
      repeat (6) step();
      en_knob = 0;
      repeat (4) step();
      en_knob = 1;
      repeat (200) step();

      // disable while a burst is outstanding
      min_dly = 2;
      n = 0;
      while (!eng_out && n < 200) begin step(); n++; end
      en_knob = 0; rr_on = 0;
      n = 0;
      while ((exp_busy || busy_nx || eng_out) && n < 100) begin step(); n++; end
      if (n >= 100) begin
         checks++; failures++;
         $display("FAIL disable_wait_timeout actual=busy required=idle");
      end
      repeat (6) step();
      min_dly = 0;

      // asynchronous reset while a command is being held
      hold = 30; en_knob = 1;
      n = 0;
      while (!s_valid && n < 20) begin step(); n++; end
      #2;
      ARESETN = 0;
      #1;
      chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("arst_cmd_addr", cmd_addr, 32'd0);
      chk("arst_row_ready", 32'(row_ready), 32'd0);
      chk("arst_row_idx", 32'(row_idx), 32'd0);
      chk("arst_cur_fb", 32'(cur_fb), 32'd0);
      chk("arst_frame_start", 32'(frame_start), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_error", 32'(error), 32'd0);
      chk("arst_underrun_cnt", 32'(underrun_cnt), 32'd0);
      model_reset();
      hold = 0; en_knob = 0; enable = 0; cmd_ready = 0; row_req = 0; done_valid = 0; swap_req = 0;
      repeat (2) step();
      ARESETN = 1;
      en_knob = 1; rr_on = 1; ur_on = 1; sw_on = 1;
      repeat (300) step();
      drain();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
